wb_master_engine: RTL and testbench
===================================

WB_MASTER_ENGINE -- requirements
Module: wb_master_engine

Interface
REQ-001 Parameter DWIDTH, 32, data bus width in bits, a multiple of 8.
REQ-002 Parameter AWIDTH, 32, address width in bits.
REQ-003 Parameter BLEN_W, 4, width of the burst-length field; maximum burst is 2**BLEN_W beats.
REQ-004 Parameter MAX_RETRY, 3, number of rty retries allowed per beat before abort.
REQ-005 Parameter TIMEOUT, 255, number of stb-high cycles without a termination before abort.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high. Ports are clk (in, 1, clock) and rst (in, 1, reset).
REQ-007 cmd_valid in 1, command offered; cmd_ready out 1, engine idle and able to accept a command.
REQ-008 cmd_we in 1, 1 for write and 0 for read; cmd_adr in AWIDTH, start byte address; cmd_sel in DWIDTH/8, byte lanes; cmd_len in BLEN_W, beat count minus 1.
REQ-009 wdat_valid in 1 and wdat in DWIDTH, write data offered; wdat_ready out 1, write data consumed this cycle.
REQ-010 rdat_valid out 1 and rdat out DWIDTH, read beat returned as a one-cycle pulse with no backpressure.
REQ-011 rsp_valid out 1 and rsp_status out 2, command complete as a one-cycle pulse; status 00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT.
REQ-012 Wishbone master outputs: cyc, stb, we (1 each), sel (DWIDTH/8), adr (AWIDTH), dout (DWIDTH), cti (3).
REQ-013 Wishbone master inputs: din (DWIDTH), ack, err, rty (1 each).

Function
REQ-014 States SHALL be IDLE, WDATA, STROBE, RETRY_GAP and DONE.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1 at a posedge.
- Acceptance latches we, adr, sel and len.
- Acceptance clears the beat, retry and timeout counters.
REQ-016 On the cycle after acceptance, cyc SHALL be 1.
- Read: state goes to STROBE.
- Write: state goes to WDATA.
REQ-017 WDATA state:
- cyc is 1 and stb is 0.
- wdat_ready equals wdat_valid.
- On a transfer, wdat is registered into dout and the state goes to STROBE on the next cycle.
REQ-018 STROBE state: stb is 1, and adr, we, sel and dout are held stable until the beat terminates.
REQ-019 Termination is sampled at the posedge with stb=1. Priority is err > rty > ack.
REQ-020 ack on a beat that is not the last:
- adr increments by DWIDTH/8, modulo 2**AWIDTH (wraps to 0).
- The retry and timeout counters clear.
- Next state: WDATA for a write, STROBE for a read (stb may stay high back-to-back).
REQ-021 ack on the last beat: next state is DONE with status 00.
REQ-022 On a read ack, rdat SHALL capture din and rdat_valid SHALL pulse on the following cycle.
REQ-023 err: next state is DONE with status 01; remaining beats are abandoned.
REQ-024 rty with retry count < MAX_RETRY: the count increments and the state goes to RETRY_GAP (stb=0 for exactly 1 cycle, cyc=1), then re-issues the same beat.
REQ-025 rty with retry count = MAX_RETRY: next state is DONE with status 10.
REQ-026 Timeout counter: increments each STROBE cycle without a termination; on reaching TIMEOUT, next state is DONE with status 11.
REQ-027 cti:
- 000 when len=0.
- 010 on non-last beats of a burst.
- 111 on the last beat of a burst.
REQ-028 DONE state: cyc=0, stb=0, rsp_valid=1 for 1 cycle, then IDLE. cmd_ready is 0 in DONE and returns to 1 in IDLE.
REQ-029 Whenever cyc=0, stb SHALL be 0.
REQ-030 A burst SHALL wrap at len=2**BLEN_W-1, giving 16 beats with default parameters; the beat counter is BLEN_W bits.

Reset
REQ-031 With rst=1 at a posedge, the state SHALL be IDLE.
- Outputs forced to 0: cyc, stb, we, sel, adr, dout, cti, rdat, rdat_valid, rsp_valid, rsp_status, wdat_ready.
- cmd_ready is 1 on the first cycle after rst deasserts.
REQ-032 Reset mid-transaction SHALL drop cyc and stb on the next posedge and SHALL emit no rsp_valid or rdat_valid for the aborted command.

Verification
REQ-033 Single write: adr=0x10, len=0, wdat=0xDEADBEEF, slave acks after 2 wait states -> one stb beat with dout=0xDEADBEEF and cti=000; rsp_status=00; cyc low the cycle after ack.
REQ-034 Read burst: adr=0x100, len=3, zero-wait slave returning 1,2,3,4 -> adr 0x100/104/108/10C; cti 010,010,010,111; four rdat_valid pulses carrying 1..4; status 00.
REQ-035 Error: 4-beat write with err on beat 2 -> beats 3 and 4 are never strobed; rsp_status=01; exactly 2 wdat transfers.
REQ-036 Retry: rty twice then ack (MAX_RETRY=3) -> three stb assertions on the same adr, each separated by a 1-cycle stb=0 gap; status 00. Four rty responses -> status 10.
REQ-037 Timeout: slave never responds, TIMEOUT=8 -> stb high for 8 cycles, then cyc=0 and rsp_status=11.
REQ-038 Reset mid-burst: rst during beat 2 of an 8-beat read -> cyc=0 on the next posedge, no rsp_valid, cmd_ready=1 after release, and the next command completes normally.

Source files
------------

// File: rtl/wb_master_engine_if.sv
// Command, write-data, read-data, response and Wishbone master signals of wb_master_engine.
// The master modport is the engine side; the slave modport is the side that drives commands and the bus slave.
interface wb_master_engine_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int BLEN_W = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [AWIDTH-1:0]     cmd_adr;
    logic [DWIDTH/8-1:0]   cmd_sel;
    logic [BLEN_W-1:0]     cmd_len;

    logic                  wdat_valid;
    logic [DWIDTH-1:0]     wdat;
    logic                  wdat_ready;

    logic                  rdat_valid;
    logic [DWIDTH-1:0]     rdat;

    logic                  rsp_valid;
    logic [1:0]            rsp_status;

    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [DWIDTH/8-1:0]   sel;
    logic [AWIDTH-1:0]     adr;
    logic [DWIDTH-1:0]     dout;
    logic [2:0]            cti;
    logic [DWIDTH-1:0]     din;
    logic                  ack;
    logic                  err;
    logic                  rty;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_len,
        input  wdat_valid, wdat,
        input  din, ack, err, rty,
        output cmd_ready, wdat_ready, rdat_valid, rdat, rsp_valid, rsp_status,
        output cyc, stb, we, sel, adr, dout, cti
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_len,
        output wdat_valid, wdat,
        output din, ack, err, rty,
        input  cmd_ready, wdat_ready, rdat_valid, rdat, rsp_valid, rsp_status,
        input  cyc, stb, we, sel, adr, dout, cti
    );
endinterface

// File: rtl/wb_master_engine.sv
// Wishbone B4 burst master: accepts a read/write command, runs up to 2**BLEN_W beats with
// retry, error and timeout handling, and reports completion with a one-cycle status pulse.
module wb_master_engine #(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 32,
    parameter int BLEN_W    = 4,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic clk,
    input  logic rst,
    wb_master_engine_if.master bus
);
    localparam int SW = DWIDTH / 8;
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ERR   = 2'b01;
    localparam logic [1:0] ST_RETRY = 2'b10;
    localparam logic [1:0] ST_TMO   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_STROBE,
        S_RETRY_GAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [AWIDTH-1:0]   adr_q, adr_d;
    logic [SW-1:0]       sel_q, sel_d;
    logic [BLEN_W-1:0]   len_q, len_d;
    logic [BLEN_W-1:0]   beat_q, beat_d;
    logic [RW-1:0]       retry_q, retry_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [DWIDTH-1:0]   dout_q, dout_d;
    logic [DWIDTH-1:0]   rdat_q, rdat_d;
    logic                rdat_valid_q, rdat_valid_d;
    logic [1:0]          status_q, status_d;
    logic                last_beat;
    logic                cyc_int;

    assign last_beat = (beat_q == len_q);
    assign cyc_int   = (state_q == S_WDATA) || (state_q == S_STROBE) || (state_q == S_RETRY_GAP);

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        adr_d        = adr_q;
        sel_d        = sel_q;
        len_d        = len_q;
        beat_d       = beat_q;
        retry_d      = retry_q;
        tmo_d        = tmo_q;
        dout_d       = dout_q;
        rdat_d       = rdat_q;
        rdat_valid_d = 1'b0;
        status_d     = status_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    we_d     = bus.cmd_we;
                    adr_d    = bus.cmd_adr;
                    sel_d    = bus.cmd_sel;
                    len_d    = bus.cmd_len;
                    beat_d   = '0;
                    retry_d  = '0;
                    tmo_d    = '0;
                    status_d = ST_OK;
                    state_d  = bus.cmd_we ? S_WDATA : S_STROBE;
                end
            end
            S_WDATA: begin
                if (bus.wdat_valid) begin
                    dout_d  = bus.wdat;
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                // Termination priority: err over rty over ack; silence feeds the timeout
                if (bus.err) begin
                    status_d = ST_ERR;
                    state_d  = S_DONE;
                end else if (bus.rty) begin
                    if (retry_q == RW'(MAX_RETRY)) begin
                        status_d = ST_RETRY;
                        state_d  = S_DONE;
                    end else begin
                        retry_d = retry_q + RW'(1);
                        tmo_d   = '0;
                        state_d = S_RETRY_GAP;
                    end
                end else if (bus.ack) begin
                    if (!we_q) begin
                        rdat_d       = bus.din;
                        rdat_valid_d = 1'b1;
                    end
                    if (last_beat) begin
                        status_d = ST_OK;
                        state_d  = S_DONE;
                    end else begin
                        adr_d   = adr_q + AWIDTH'(SW);
                        beat_d  = beat_q + BLEN_W'(1);
                        retry_d = '0;
                        tmo_d   = '0;
                        state_d = we_q ? S_WDATA : S_STROBE;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    status_d = ST_TMO;
                    state_d  = S_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RETRY_GAP: state_d = S_STROBE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset clears the datapath too so an aborted command leaves no stale bus values behind
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q         <= 1'b0;
            adr_q        <= '0;
            sel_q        <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            retry_q      <= '0;
            tmo_q        <= '0;
            dout_q       <= '0;
            rdat_q       <= '0;
            rdat_valid_q <= 1'b0;
            status_q     <= ST_OK;
        end else begin
            we_q         <= we_d;
            adr_q        <= adr_d;
            sel_q        <= sel_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            retry_q      <= retry_d;
            tmo_q        <= tmo_d;
            dout_q       <= dout_d;
            rdat_q       <= rdat_d;
            rdat_valid_q <= rdat_valid_d;
            status_q     <= status_d;
        end
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.wdat_ready = (state_q == S_WDATA) && bus.wdat_valid;
    assign bus.rdat_valid = rdat_valid_q;
    assign bus.rdat       = rdat_q;
    assign bus.rsp_valid  = (state_q == S_DONE);
    assign bus.rsp_status = status_q;
    assign bus.cyc        = cyc_int;
    assign bus.stb        = (state_q == S_STROBE);
    assign bus.we         = we_q;
    assign bus.sel        = sel_q;
    assign bus.adr        = adr_q;
    assign bus.dout       = dout_q;
    assign bus.cti        = !cyc_int         ? 3'b000 :
                            (len_q == '0)    ? 3'b000 :
                            last_beat        ? 3'b111 : 3'b010;
endmodule

// File: tb/tb_wb_master_engine.sv
// Directed bench for wb_master_engine: a scripted Wishbone slave plus a negedge monitor,
// with hand-computed expectations for write, burst read, error, retry, timeout and reset cases.
module tb_wb_master_engine;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_master_engine_if #(.DWIDTH(DW), .AWIDTH(AW), .BLEN_W(BW)) bus ();

    wb_master_engine #(
        .DWIDTH(DW), .AWIDTH(AW), .BLEN_W(BW), .MAX_RETRY(3), .TIMEOUT(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Slave behaviour knobs
    int ws, err_beat, rty_beat, rty_cnt;
    bit mute;
    logic [31:0] rd_base;
    // Slave and monitor state
    int wait_cnt, beat_idx, rty_seen, resp_kind;
    int n_beats, stb_rises, stb_hi, rdv, wd_xfers, gap_bad, low_run;
    int cyc_n, term_cyc, rsp_cyc, bad_stb, rsp_cnt;
    bit wd_pend;
    logic prev_stb;
    logic [31:0] adr_log [32];
    logic [2:0]  cti_log [32];
    logic [31:0] dout_log[32];
    logic [31:0] rdat_log[32];
    logic [31:0] wdata_tab[16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_state();
        ws = 0; err_beat = -1; rty_beat = -1; rty_cnt = 0; mute = 1'b0; rd_base = 32'h0;
        wait_cnt = 0; beat_idx = 0; rty_seen = 0; resp_kind = 0;
        n_beats = 0; stb_rises = 0; stb_hi = 0; rdv = 0; wd_xfers = 0; gap_bad = 0; low_run = 0;
        term_cyc = 0; rsp_cyc = 0; rsp_cnt = 0; wd_pend = 1'b0; prev_stb = 1'b0;
    endtask

    task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [3:0] len);
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_sel   = 4'hF;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [1:0] st, output logic cyc_at);
        bit seen = 1'b0;
        st = 2'b00;
        cyc_at = 1'b1;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            if (bus.rsp_valid) begin
                seen = 1'b1;
                st = bus.rsp_status;
                cyc_at = bus.cyc;
            end
        end
        check("rsp_seen", 64'(seen), 64'd1);
        tick();
        tick();
    endtask

    // Monitor and scripted slave; responses are driven at negedge and sampled by the DUT at posedge
    always @(negedge clk) begin
        cyc_n++;
        if (resp_kind != 0) begin
            if (resp_kind == 1) beat_idx++;
            if (resp_kind == 3) rty_seen++;
            resp_kind = 0;
            wait_cnt = 0;
        end
        if (bus.stb && !bus.cyc) bad_stb++;
        if (bus.stb) begin
            stb_hi++;
            if (!prev_stb) begin
                stb_rises++;
                if (low_run > 0 && low_run != 1) gap_bad++;
            end
            low_run = 0;
        end else if (bus.cyc) begin
            low_run++;
        end else begin
            low_run = 0;
        end
        prev_stb = bus.stb;
        if (bus.rdat_valid) begin
            if (rdv < 32) rdat_log[rdv] = bus.rdat;
            rdv++;
        end
        if (bus.rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc_n;
        end
        if (wd_pend) wd_xfers++;
        wd_pend = bus.wdat_ready;
        bus.wdat = wdata_tab[wd_xfers % 16];
        bus.ack = 1'b0;
        bus.err = 1'b0;
        bus.rty = 1'b0;
        if (bus.stb && !mute && !rst) begin
            if (wait_cnt < ws) begin
                wait_cnt++;
            end else begin
                if (n_beats < 32) begin
                    adr_log[n_beats]  = bus.adr;
                    cti_log[n_beats]  = bus.cti;
                    dout_log[n_beats] = bus.dout;
                end
                n_beats++;
                term_cyc = cyc_n;
                if (beat_idx == err_beat) begin
                    bus.err = 1'b1;
                    resp_kind = 2;
                end else if (beat_idx == rty_beat && rty_seen < rty_cnt) begin
                    bus.rty = 1'b1;
                    resp_kind = 3;
                end else begin
                    bus.ack = 1'b1;
                    bus.din = rd_base + 32'(beat_idx);
                    resp_kind = 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] st;
        logic cyc_at;
        bit reached;
        int rdv_before, rsp_before;

        cyc_n = 0; bad_stb = 0;
        clear_state();
        for (int i = 0; i < 16; i++) wdata_tab[i] = 32'h0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = '0; bus.cmd_sel = '0; bus.cmd_len = '0;
        bus.wdat_valid = 1'b0;
        repeat (3) @(posedge clk);
        tick();
        // Reset state
        check("rst_cyc",        64'(bus.cyc), 64'd0);
        check("rst_stb",        64'(bus.stb), 64'd0);
        check("rst_adr",        64'(bus.adr), 64'd0);
        check("rst_dout",       64'(bus.dout), 64'd0);
        check("rst_cti",        64'(bus.cti), 64'd0);
        check("rst_rsp_valid",  64'(bus.rsp_valid), 64'd0);
        check("rst_rdat_valid", 64'(bus.rdat_valid), 64'd0);
        check("rst_wdat_ready", 64'(bus.wdat_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        bus.wdat_valid = 1'b1;

        // Single write, two wait states
        tick();
        clear_state();
        ws = 2;
        wdata_tab[0] = 32'hDEADBEEF;
        do_cmd(1'b1, 32'h10, 4'd0);
        wait_rsp(st, cyc_at);
        check("wr1_status",   64'(st), 64'd0);
        check("wr1_cyc_rsp",  64'(cyc_at), 64'd0);
        check("wr1_beats",    64'(n_beats), 64'd1);
        check("wr1_dout",     64'(dout_log[0]), 64'hDEADBEEF);
        check("wr1_adr",      64'(adr_log[0]), 64'h10);
        check("wr1_cti",      64'(cti_log[0]), 64'd0);
        check("wr1_stb_hi",   64'(stb_hi), 64'd3);
        check("wr1_xfers",    64'(wd_xfers), 64'd1);
        check("wr1_ack2rsp",  64'(rsp_cyc - term_cyc), 64'd1);

        // Zero-wait 4-beat read burst
        clear_state();
        rd_base = 32'd1;
        do_cmd(1'b0, 32'h100, 4'd3);
        wait_rsp(st, cyc_at);
        check("rd4_status", 64'(st), 64'd0);
        check("rd4_beats",  64'(n_beats), 64'd4);
        check("rd4_rises",  64'(stb_rises), 64'd1);
        check("rd4_rdv",    64'(rdv), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rd4_adr%0d", i),  64'(adr_log[i]), 64'(32'h100 + 32'(4 * i)));
            check($sformatf("rd4_cti%0d", i),  64'(cti_log[i]), (i == 3) ? 64'd7 : 64'd2);
            check($sformatf("rd4_rdat%0d", i), 64'(rdat_log[i]), 64'(i + 1));
        end

        // 4-beat write with err on the second beat
        clear_state();
        err_beat = 1;
        for (int i = 0; i < 4; i++) wdata_tab[i] = 32'hA0 + 32'(i);
        do_cmd(1'b1, 32'h80, 4'd3);
        wait_rsp(st, cyc_at);
        check("err_status", 64'(st), 64'd1);
        check("err_beats",  64'(n_beats), 64'd2);
        check("err_rises",  64'(stb_rises), 64'd2);
        check("err_xfers",  64'(wd_xfers), 64'd2);
        check("err_adr1",   64'(adr_log[1]), 64'h84);
        check("err_dout1",  64'(dout_log[1]), 64'hA1);

        // Two rty then ack
        clear_state();
        rty_beat = 0; rty_cnt = 2; rd_base = 32'h77;
        do_cmd(1'b0, 32'h40, 4'd0);
        wait_rsp(st, cyc_at);
        check("rty2_status", 64'(st), 64'd0);
        check("rty2_rises",  64'(stb_rises), 64'd3);
        check("rty2_gaps",   64'(gap_bad), 64'd0);
        check("rty2_adr0",   64'(adr_log[0]), 64'h40);
        check("rty2_adr2",   64'(adr_log[2]), 64'h40);
        check("rty2_rdat",   64'(rdat_log[0]), 64'h77);

        // Four rty exhaust the retries
        clear_state();
        rty_beat = 0; rty_cnt = 4;
        do_cmd(1'b0, 32'h40, 4'd0);
        wait_rsp(st, cyc_at);
        check("rty4_status", 64'(st), 64'd2);
        check("rty4_rises",  64'(stb_rises), 64'd4);
        check("rty4_rdv",    64'(rdv), 64'd0);
        check("rty4_gaps",   64'(gap_bad), 64'd0);

        // Silent slave: timeout after 8 strobe cycles
        clear_state();
        mute = 1'b1;
        do_cmd(1'b0, 32'h20, 4'd0);
        wait_rsp(st, cyc_at);
        check("tmo_status", 64'(st), 64'd3);
        check("tmo_cyc",    64'(cyc_at), 64'd0);
        check("tmo_stb_hi", 64'(stb_hi), 64'd8);

        // 16-beat burst crossing the top of the address space
        clear_state();
        rd_base = 32'h100;
        do_cmd(1'b0, 32'hFFFF_FFF0, 4'd15);
        wait_rsp(st, cyc_at);
        check("b16_status", 64'(st), 64'd0);
        check("b16_beats",  64'(n_beats), 64'd16);
        check("b16_adr4",   64'(adr_log[4]), 64'h0);
        check("b16_adr15",  64'(adr_log[15]), 64'h2C);
        check("b16_cti14",  64'(cti_log[14]), 64'd2);
        check("b16_cti15",  64'(cti_log[15]), 64'd7);
        check("b16_rdat15", 64'(rdat_log[15]), 64'h10F);

        // Reset during beat 2 of an 8-beat read
        clear_state();
        ws = 3; rd_base = 32'h50;
        do_cmd(1'b0, 32'h300, 4'd7);
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            tick();
            if (beat_idx == 1 && bus.stb && wait_cnt == 1) reached = 1'b1;
        end
        check("mrst_reached", 64'(reached), 64'd1);
        rdv_before = rdv;
        rsp_before = rsp_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_cyc",  64'(bus.cyc), 64'd0);
        check("mrst_stb",  64'(bus.stb), 64'd0);
        check("mrst_adr",  64'(bus.adr), 64'd0);
        tick();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        repeat (4) tick();
        check("mrst_no_rsp", 64'(rsp_cnt - rsp_before), 64'd0);
        check("mrst_no_rdv", 64'(rdv - rdv_before), 64'd0);
        clear_state();
        rd_base = 32'h60;
        do_cmd(1'b0, 32'h200, 4'd1);
        wait_rsp(st, cyc_at);
        check("post_status", 64'(st), 64'd0);
        check("post_rdv",    64'(rdv), 64'd2);
        check("post_adr1",   64'(adr_log[1]), 64'h204);
        check("post_rdat1",  64'(rdat_log[1]), 64'h61);

        check("stb_without_cyc", 64'(bad_stb), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
